acc_drain: RTL and testbench
============================

Name: acc_drain

Overview:
- Readout engine on the read port of the 16-entry x 384-bit tile accumulator; the consuming side of the interface that the MAC datapath writes.
- On i_start, reads every accumulator entry in order and serialises each 384-bit entry into fixed-width beats on a valid/ready output stream, toward the output buffer or writeback path.
- Asserts a done pulse after the last beat.
- Sits beside mm_ctrl; the accumulator write port is owned by the MAC path except when the optional clear feature is compiled in.

Parameters:
- VEC_WIDTH, 384, accumulator entry width in bits.
- ARR_DEPTH, 16, number of accumulator entries drained per start.
- AW, 4, accumulator address width; ARR_DEPTH <= 2^AW.
- OUT_WIDTH, 96, output beat width; VEC_WIDTH % OUT_WIDTH == 0; BEATS = VEC_WIDTH/OUT_WIDTH (4 by default).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  start a full drain; sampled only in IDLE.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse after the final beat is accepted.
- o_rd_addr  out  AW  accumulator read address.
- i_rd_data  in  VEC_WIDTH  accumulator read data, valid one cycle after o_rd_addr is presented.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream ready.
- o_data  out  OUT_WIDTH  output beat.
- o_last  out  1  high on the final beat of the final entry.
- o_acc_we  out  1  accumulator clear write enable (ACC_DRAIN_CLEAR_EN only, else tied 0).
- o_acc_addr  out  AW  clear address.
- o_acc_data  out  VEC_WIDTH  clear data, always 0.

Behaviour:
- Reset (i_rst=1 at a rising edge) → state IDLE, entry counter 0, beat counter 0. All outputs are 0: o_busy, o_done, o_valid, o_last, o_rd_addr, o_data, o_acc_we.
- Reset mid-drain aborts immediately. No done pulse; the partial stream is discarded; o_valid drops the cycle after reset.
- FSM states: IDLE, RD, CAP, SEND, DONE.
- IDLE: i_start=1 → RD with entry=0. Otherwise stay in IDLE.
- RD: drive o_rd_addr=entry for 1 cycle → CAP.
- CAP: register i_rd_data into the shift register; beat=0 → SEND. o_rd_addr holds its value through CAP and SEND.
- SEND, output: o_valid=1; o_data = shift register bits [OUT_WIDTH-1:0], LSB slice first.
- SEND, handshake: a beat transfers when o_valid && i_ready. On transfer, shift the register right by OUT_WIDTH and increment beat.
- SEND, backpressure: while i_ready=0, o_data, o_valid and o_last hold stable; o_valid never drops before transfer.
- SEND, end of entry: on transfer with beat==BEATS-1, go to DONE if entry==ARR_DEPTH-1, else to RD with entry+1.
- o_last = (state==SEND) && beat==BEATS-1 && entry==ARR_DEPTH-1.
- DONE: o_done=1 for exactly 1 cycle → IDLE. i_start is ignored in DONE.
- i_start is ignored in RD/CAP/SEND/DONE; it is not queued.
- Throughput: no prefetch. Each entry costs 2 + BEATS cycles plus any stall cycles.
- Timing at defaults with i_ready=1:
  - start sampled at cycle 0; RD in cycle 1; CAP in cycle 2; first o_valid in cycle 3.
  - last beat in cycle 96; o_done in cycle 97.
- Entry counter and beat counter do not wrap within a drain. Both return to 0 on entry to IDLE.

Optional Feature:
- ACC_DRAIN_CLEAR_EN defined:
  - In the CAP cycle, assert o_acc_we=1 with o_acc_addr=entry and o_acc_data=0, zeroing the entry just read for the next tile.
  - The read in RD precedes the clear, so the captured data is the pre-clear value.
  - The MAC path must not write the accumulator while o_busy=1.
- ACC_DRAIN_CLEAR_EN undefined: o_acc_we, o_acc_addr and o_acc_data are constant 0; the accumulator is unmodified.

Test Plan:
- Basic drain: accumulator entry k preloaded with each 24-bit lane = k*16+lane, i_ready=1, start at cycle 0 → 64 beats in cycles 3..96.
  - Beat 0 = lanes 0-3 of entry 0; o_last only in cycle 96.
  - o_done only in cycle 97; o_busy low from cycle 98.
- Backpressure: i_ready toggles 1/0 every cycle plus a 10-cycle hold low during entry 5 → all 64 beats in order, no duplicates; o_data stable during stalls; o_done after the final accepted beat.
- Start while busy: i_start pulsed in cycles 5, 40 and 97 (DONE) → exactly one drain of 64 beats; start accepted again from IDLE in cycle 98.
- Reset mid-drain: i_rst=1 in cycle 30 → next cycle o_valid=0, o_busy=0, o_done never pulses. A new start then yields a full 64 beats beginning at entry 0.
- Clear feature (ACC_DRAIN_CLEAR_EN): drain with data preloaded → o_acc_we pulses 16 times with addresses 0..15, one per CAP cycle. A second drain outputs 64 all-zero beats.
- Without the macro: two back-to-back drains output identical nonzero data; o_acc_we is never asserted.

Source files
------------

// File: rtl/acc_drain.sv
// Drains the 16 x 384-bit tile accumulator into OUT_WIDTH-bit valid/ready beats, LSB slice first.
// Build option ACC_DRAIN_CLEAR_EN: zero each entry through the accumulator write port as it is captured.
module acc_drain #(
    parameter int VEC_WIDTH = 384,
    parameter int ARR_DEPTH = 16,
    parameter int AW        = 4,
    parameter int OUT_WIDTH = 96
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [AW-1:0]        o_rd_addr,
    input  logic [VEC_WIDTH-1:0] i_rd_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_last,
    output logic                 o_acc_we,
    output logic [AW-1:0]        o_acc_addr,
    output logic [VEC_WIDTH-1:0] o_acc_data
);

    localparam int BEATS = VEC_WIDTH / OUT_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [AW-1:0] LAST_ENTRY = AW'(ARR_DEPTH - 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [AW-1:0]          entry;
    logic [BW-1:0]          beat;
    logic [VEC_WIDTH-1:0]   shreg;
    logic                   xfer;
    logic                   last_beat;
    logic                   last_entry;

    assign xfer       = (state == SEND) && i_ready;
    assign last_beat  = (beat == LAST_BEAT);
    assign last_entry = (entry == LAST_ENTRY);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (i_start) state_nx = RD;
            RD:   state_nx = CAP;
            CAP:  state_nx = SEND;
            SEND: begin
                if (xfer && last_beat) begin
                    state_nx = last_entry ? DONE : RD;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Entry/beat counters are cleared in DONE so IDLE always presents address 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            entry <= '0;
            beat  <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    entry <= '0;
                    beat  <= '0;
                end
                CAP: begin
                    shreg <= i_rd_data;
                    beat  <= '0;
                end
                SEND: begin
                    if (i_ready) begin
                        shreg <= shreg >> OUT_WIDTH;
                        if (last_beat) begin
                            if (!last_entry) entry <= entry + 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DONE: begin
                    entry <= '0;
                    beat  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (state != IDLE);
    assign o_done    = (state == DONE);
    assign o_valid   = (state == SEND);
    assign o_last    = (state == SEND) && last_beat && last_entry;
    assign o_rd_addr = entry;
    assign o_data    = shreg[OUT_WIDTH-1:0];

`ifdef ACC_DRAIN_CLEAR_EN
    // The read was issued in RD, so clearing in CAP never disturbs the captured value.
    assign o_acc_we   = (state == CAP);
    assign o_acc_addr = (state == CAP) ? entry : '0;
`else
    assign o_acc_we   = 1'b0;
    assign o_acc_addr = '0;
`endif
    assign o_acc_data = '0;

endmodule

// File: tb/tb_acc_drain.sv
// Self-checking bench for acc_drain: accumulator plant, expected beat stream rebuilt from expected contents.
module tb_acc_drain;
    localparam int VW = 384;
    localparam int OW = 96;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int NB = VW / OW;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_start = 1'b0;
    logic           i_ready = 1'b1;
    logic           o_busy, o_done, o_valid, o_last, o_acc_we;
    logic [AW-1:0]  o_rd_addr, o_acc_addr;
    logic [VW-1:0]  rd_data = '0;
    logic [VW-1:0]  o_acc_data;
    logic [OW-1:0]  o_data;

    logic [VW-1:0]  acc_mem  [D];
    logic [VW-1:0]  load_img [D];
    logic [VW-1:0]  exp_mem  [D];
    logic           load_pulse = 1'b0;

    int tests = 0;
    int fails = 0;

    acc_drain dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_rd_addr(o_rd_addr), .i_rd_data(rd_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_last(o_last), .o_acc_we(o_acc_we), .o_acc_addr(o_acc_addr),
        .o_acc_data(o_acc_data)
    );

    always #5 i_clk = ~i_clk;

    // Accumulator: registered read, write port driven by the DUT clear or a bench preload.
    always @(posedge i_clk) begin
        rd_data <= acc_mem[o_rd_addr];
        if (load_pulse) begin
            for (int k = 0; k < D; k++) acc_mem[k] <= load_img[k];
        end else if (o_acc_we) begin
            acc_mem[o_acc_addr] <= o_acc_data;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input bit pattern);
        for (int k = 0; k < D; k++) begin
            if (pattern) begin
                for (int l = 0; l < VW / 24; l++) load_img[k][l*24 +: 24] = 24'(k * 16 + l);
            end else begin
                for (int w = 0; w < VW / 32; w++) load_img[k][w*32 +: 32] = $urandom;
            end
            exp_mem[k] = load_img[k];
        end
        load_pulse = 1'b1;
        tick();
        load_pulse = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready toggling plus a 10-cycle stall in entry 5;
    // mode 2: ready high with start pulses while busy and in DONE.
    task automatic drain(input int mode, input string tag);
        logic [OW-1:0] q[$];
        logic [OW-1:0] prev_data = '0;
        logic [OW-1:0] expd;
        bit prev_stall = 0, held = 0;
        int cyc = 0, beats = 0, dones = 0, hold = 0, we_cnt = 0;
        int first_v = -1, last_cyc = -1, done_cyc = -1;
        for (int k = 0; k < D; k++)
            for (int b = 0; b < NB; b++) q.push_back(exp_mem[k][b*OW +: OW]);
        i_start = 1'b1;
        i_ready = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 1;
        while (cyc < 2000) begin
            if (mode == 2) i_start = (cyc == 5 || cyc == 40 || cyc == 97);
            if (mode == 1) begin
                if (!held && beats == 21) begin hold = 10; held = 1; end
                if (hold > 0) begin i_ready = 1'b0; hold--; end
                else i_ready = (cyc % 2 == 1);
            end else begin
                i_ready = 1'b1;
            end
            if (o_acc_we) begin
                chk({tag, "_clr_addr"}, VW'(o_acc_addr), VW'(we_cnt));
                chk({tag, "_clr_data"}, o_acc_data, '0);
                we_cnt++;
            end
            if (prev_stall) begin
                chk({tag, "_stall_valid"}, VW'(o_valid), VW'(1));
                chk({tag, "_stall_data"}, VW'(o_data), VW'(prev_data));
            end
            if (o_valid) begin
                if (first_v < 0) first_v = cyc;
                chk({tag, "_last"}, VW'(o_last), VW'(beats == D * NB - 1));
                if (i_ready) begin
                    expd = (q.size() > 0) ? q.pop_front() : '0;
                    chk({tag, "_beat"}, VW'(o_data), VW'(expd));
                    beats++;
                    last_cyc = cyc;
                end
            end
            if (o_done) begin dones++; done_cyc = cyc; end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            if (dones > 0 && !o_busy) break;
            tick();
            cyc++;
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        chk({tag, "_nbeats"}, VW'(beats), VW'(D * NB));
        chk({tag, "_ndone"}, VW'(dones), VW'(1));
        chk({tag, "_done_after_last"}, VW'(done_cyc), VW'(last_cyc + 1));
`ifdef ACC_DRAIN_CLEAR_EN
        chk({tag, "_nclear"}, VW'(we_cnt), VW'(D));
        for (int k = 0; k < D; k++) exp_mem[k] = '0;
`else
        chk({tag, "_nclear"}, VW'(we_cnt), VW'(0));
`endif
        if (mode != 1) begin
            chk({tag, "_first_valid_cyc"}, VW'(first_v), VW'(3));
            chk({tag, "_last_cyc"}, VW'(last_cyc), VW'(96));
            chk({tag, "_done_cyc"}, VW'(done_cyc), VW'(97));
            chk({tag, "_idle_cyc"}, VW'(cyc), VW'(98));
        end
    endtask

    initial begin
        // Reset state
        i_rst = 1'b1;
        tick();
        tick();
        chk("rst_busy",  VW'(o_busy),    VW'(0));
        chk("rst_done",  VW'(o_done),    VW'(0));
        chk("rst_valid", VW'(o_valid),   VW'(0));
        chk("rst_last",  VW'(o_last),    VW'(0));
        chk("rst_addr",  VW'(o_rd_addr), VW'(0));
        chk("rst_data",  VW'(o_data),    VW'(0));
        chk("rst_we",    VW'(o_acc_we),  VW'(0));
        i_rst = 1'b0;
        tick();

        // Basic drain with lane pattern, then a second drain of the same accumulator
        load(1'b1);
        chk("pattern_beat0", VW'(exp_mem[0][OW-1:0]), VW'({24'd3, 24'd2, 24'd1, 24'd0}));
        drain(0, "basic");
        drain(0, "second");

        // Backpressure on random data
        load(1'b0);
        drain(1, "bp");

        // Start pulses while busy and in DONE, then a fresh start from IDLE
        load(1'b0);
        drain(2, "busy_start");
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("restart_busy", VW'(o_busy), VW'(1));
        chk("restart_addr", VW'(o_rd_addr), VW'(0));
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;

        // Reset mid-drain
        load(1'b0);
        i_start = 1'b1;
        i_ready = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c < 30; c++) tick();
        chk("mid_valid_pre", VW'(o_busy), VW'(1));
        i_rst = 1'b1;
        tick();
        chk("abort_valid", VW'(o_valid), VW'(0));
        chk("abort_busy",  VW'(o_busy),  VW'(0));
        chk("abort_done",  VW'(o_done),  VW'(0));
        i_rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("abort_no_done", VW'({o_done, o_busy}), VW'(0));
            tick();
        end
        load(1'b0);
        drain(0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
